// File: rtl/riscv_decode_pkg.sv
// riscv_decode_pkg
//   Shared RV32I pre-decode definitions used by the prefetch queue and the
//   operation controller.
//   Contents:
//     - 7-bit major opcode constants for the ten supported classes
//     - NOP_INSTRUCTION (addi x0,x0,0) and EMPTY_DECODED, the values that an
//       empty queue presents on its issue port
//     - bit positions of each class in the 10-bit one-hot decoded vector
//     - imm_format_e and format_immediate(), which extract and sign-extend
//       the immediate field of an instruction word
package riscv_decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_IMM    = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  localparam int DECODED_WIDTH = 10;

  // Bit positions inside the decoded vector
  // {system, jal, jalr, branch, lui, operation, store, auipc, immediate, load}
  localparam int DEC_LOAD      = 0;
  localparam int DEC_IMMEDIATE = 1;
  localparam int DEC_AUIPC     = 2;
  localparam int DEC_STORE     = 3;
  localparam int DEC_OPERATION = 4;
  localparam int DEC_LUI       = 5;
  localparam int DEC_BRANCH    = 6;
  localparam int DEC_JALR      = 7;
  localparam int DEC_JAL       = 8;
  localparam int DEC_SYSTEM    = 9;

  // Decode of the NOP: immediate and operation classes
  localparam logic [DECODED_WIDTH-1:0] EMPTY_DECODED = 10'h012;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_format_e;

  function automatic logic [31:0] format_immediate(input imm_format_e fmt,
                                                   input logic [31:0] word);
    logic [31:0] imm;
    case (fmt)
      IMM_S:   imm = {{21{word[31]}}, word[30:25], word[11:7]};
      IMM_B:   imm = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
      IMM_U:   imm = {word[31:12], 12'b0};
      IMM_J:   imm = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
      default: imm = {{21{word[31]}}, word[30:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/instruction_predecoder.sv
// instruction_predecoder
//   Purely combinational pre-decode of one RV32I instruction word.
//   Ports:
//     instruction_i  32  instruction word
//     decoded_o      10  one-hot instruction class (operation also set for OP-IMM)
//     immediate_o    32  immediate in the format implied by the opcode
//     illegal_o       1  opcode matches none of the supported classes
module instruction_predecoder
  import riscv_decode_pkg::*;
(
  input  logic [31:0]              instruction_i,
  output logic [DECODED_WIDTH-1:0] decoded_o,
  output logic [31:0]              immediate_o,
  output logic                     illegal_o
);

  imm_format_e imm_format;

  always_comb begin
    decoded_o  = '0;
    imm_format = IMM_I;
    case (instruction_i[6:0])
      OPC_LOAD:   decoded_o[DEC_LOAD] = 1'b1;
      OPC_IMM: begin
        // OP-IMM also flags the ALU operation class so the controller
        // treats it like a register-register op with an immediate operand.
        decoded_o[DEC_IMMEDIATE] = 1'b1;
        decoded_o[DEC_OPERATION] = 1'b1;
      end
      OPC_AUIPC: begin
        decoded_o[DEC_AUIPC] = 1'b1;
        imm_format           = IMM_U;
      end
      OPC_STORE: begin
        decoded_o[DEC_STORE] = 1'b1;
        imm_format           = IMM_S;
      end
      OPC_OP:     decoded_o[DEC_OPERATION] = 1'b1;
      OPC_LUI: begin
        decoded_o[DEC_LUI] = 1'b1;
        imm_format         = IMM_U;
      end
      OPC_BRANCH: begin
        decoded_o[DEC_BRANCH] = 1'b1;
        imm_format            = IMM_B;
      end
      OPC_JALR:   decoded_o[DEC_JALR] = 1'b1;
      OPC_JAL: begin
        decoded_o[DEC_JAL] = 1'b1;
        imm_format         = IMM_J;
      end
      OPC_SYSTEM: decoded_o[DEC_SYSTEM] = 1'b1;
      default:    decoded_o = '0;
    endcase
  end

  assign immediate_o = format_immediate(imm_format, instruction_i);
  assign illegal_o   = ~|decoded_o;

endmodule

// File: rtl/instruction_prefetch_queue.sv
// instruction_prefetch_queue
//   In-order prefetch queue with pre-decode on entry. Words are decoded as
//   they are accepted, stored DEPTH deep with their fetch address, and issued
//   through a valid/ready handshake. A flush empties the queue in one cycle;
//   an empty queue presents the canonical NOP on every issue output.
//   Ports:
//     clock, reset_n          clock (rising edge), async active-low reset
//     fetch_valid/ready       fetch handshake; ready depends on state only
//     fetch_instruction/addr  fetched word and its address
//     flush                   discard all entries (jump or system jump)
//     issue_valid/ready       issue handshake for the head entry
//     issue_instruction/address/decoded/immediate/illegal  head entry fields
//     occupancy               number of valid entries
module instruction_prefetch_queue
  import riscv_decode_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         fetch_valid,
  input  logic [31:0]                  fetch_instruction,
  input  logic [ADDR_WIDTH-1:0]        fetch_address,
  output logic                         fetch_ready,
  input  logic                         flush,
  input  logic                         issue_ready,
  output logic                         issue_valid,
  output logic [31:0]                  issue_instruction,
  output logic [ADDR_WIDTH-1:0]        issue_address,
  output logic [DECODED_WIDTH-1:0]     issue_decoded,
  output logic [31:0]                  issue_immediate,
  output logic                         issue_illegal,
  output logic [$clog2(DEPTH):0]       occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);

  // Entry storage: plain flops, deliberately left out of reset
  logic [31:0]              instr_mem   [DEPTH];
  logic [ADDR_WIDTH-1:0]    addr_mem    [DEPTH];
  logic [DECODED_WIDTH-1:0] decoded_mem [DEPTH];
  logic [31:0]              imm_mem     [DEPTH];
  logic                     illegal_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic [DECODED_WIDTH-1:0] fetch_decoded;
  logic [31:0]              fetch_immediate;
  logic                     fetch_illegal;
  logic                     enqueue;
  logic                     dequeue;

  instruction_predecoder u_predecoder (
    .instruction_i (fetch_instruction),
    .decoded_o     (fetch_decoded),
    .immediate_o   (fetch_immediate),
    .illegal_o     (fetch_illegal)
  );

  // Both handshake flags come from registered occupancy only, so there is
  // no combinational path from issue_ready to fetch_ready.
  assign fetch_ready = (occ_q != FULL_COUNT);
  assign issue_valid = (occ_q != '0);
  assign enqueue     = fetch_valid & fetch_ready;
  assign dequeue     = issue_valid & issue_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      // Flush wins over any same-cycle enqueue or dequeue
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (enqueue) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (dequeue) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enqueue, dequeue})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // One write-enabled register slot per entry
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clock) begin
      if (enqueue && !flush && (wr_ptr_q == PTR_W'(gi))) begin
        instr_mem[gi]   <= fetch_instruction;
        addr_mem[gi]    <= fetch_address;
        decoded_mem[gi] <= fetch_decoded;
        imm_mem[gi]     <= fetch_immediate;
        illegal_mem[gi] <= fetch_illegal;
      end
    end
  end

  // Issue path is a read mux of the head entry with the NOP substituted
  // when empty; decoding already happened at enqueue.
  assign issue_instruction = issue_valid ? instr_mem[rd_ptr_q]   : NOP_INSTRUCTION;
  assign issue_address     = issue_valid ? addr_mem[rd_ptr_q]    : '0;
  assign issue_decoded     = issue_valid ? decoded_mem[rd_ptr_q] : EMPTY_DECODED;
  assign issue_immediate   = issue_valid ? imm_mem[rd_ptr_q]     : 32'h0;
  assign issue_illegal     = issue_valid ? illegal_mem[rd_ptr_q] : 1'b0;
  assign occupancy         = occ_q;

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
module tb_instruction_prefetch_queue;

  logic        clock;
  logic        reset_n;
  logic        fetch_valid;
  logic [31:0] fetch_instruction;
  logic [31:0] fetch_address;
  logic        fetch_ready;
  logic        flush;
  logic        issue_ready;
  logic        issue_valid;
  logic [31:0] issue_instruction;
  logic [31:0] issue_address;
  logic [9:0]  issue_decoded;
  logic [31:0] issue_immediate;
  logic        issue_illegal;
  logic [2:0]  occupancy;

  instruction_prefetch_queue #(.DEPTH(4), .ADDR_WIDTH(32)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .fetch_valid       (fetch_valid),
    .fetch_instruction (fetch_instruction),
    .fetch_address     (fetch_address),
    .fetch_ready       (fetch_ready),
    .flush             (flush),
    .issue_ready       (issue_ready),
    .issue_valid       (issue_valid),
    .issue_instruction (issue_instruction),
    .issue_address     (issue_address),
    .issue_decoded     (issue_decoded),
    .issue_immediate   (issue_immediate),
    .issue_illegal     (issue_illegal),
    .occupancy         (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] ins;
    logic [9:0]  dec;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] addr;
    logic [9:0]  dec;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  // Hand-decoded instruction words
  vec_t vtab [14];
  exp_t exp_q [$];
  int   vectors = 0;
  int   miscompares = 0;
  int   model_occ = 0;

  initial begin
    vtab[0]  = '{32'h00500093, 10'h012, 32'h00000005, 1'b0}; // addi x1,x0,5
    vtab[1]  = '{32'hFE000EE3, 10'h040, 32'hFFFFFFFC, 1'b0}; // beq x0,x0,-4
    vtab[2]  = '{32'h00112623, 10'h008, 32'h0000000C, 1'b0}; // sw x1,12(x2)
    vtab[3]  = '{32'h12345037, 10'h020, 32'h12345000, 1'b0}; // lui x0,0x12345
    vtab[4]  = '{32'hFFFFFFFF, 10'h000, 32'hFFFFFFFF, 1'b1}; // illegal
    vtab[5]  = '{32'h0000006F, 10'h100, 32'h00000000, 1'b0}; // jal x0,0
    vtab[6]  = '{32'h00008067, 10'h080, 32'h00000000, 1'b0}; // jalr x0,0(x1)
    vtab[7]  = '{32'h00000073, 10'h200, 32'h00000000, 1'b0}; // ecall
    vtab[8]  = '{32'h00000517, 10'h004, 32'h00000000, 1'b0}; // auipc x10,0
    vtab[9]  = '{32'h00A00033, 10'h010, 32'h0000000A, 1'b0}; // OP, I-field 0x00A
    vtab[10] = '{32'hFFC10083, 10'h001, 32'hFFFFFFFC, 1'b0}; // lb x1,-4(x2)
    vtab[11] = '{32'h800000EF, 10'h100, 32'hFFF00000, 1'b0}; // jal x1,-1MiB
    vtab[12] = '{32'hFE112E23, 10'h008, 32'hFFFFFFFC, 1'b0}; // sw x1,-4(x2)
    vtab[13] = '{32'h00000463, 10'h040, 32'h00000008, 1'b0}; // beq x0,x0,8
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  task automatic check_empty(input string tag);
    chk({tag, " issue_valid"},       {31'b0, issue_valid}, 32'h0);
    chk({tag, " issue_instruction"}, issue_instruction, 32'h00000013);
    chk({tag, " issue_address"},     issue_address, 32'h0);
    chk({tag, " issue_decoded"},     {22'b0, issue_decoded}, 32'h012);
    chk({tag, " issue_immediate"},   issue_immediate, 32'h0);
    chk({tag, " issue_illegal"},     {31'b0, issue_illegal}, 32'h0);
    chk({tag, " fetch_ready"},       {31'b0, fetch_ready}, 32'h1);
    chk({tag, " occupancy"},         {29'b0, occupancy}, 32'h0);
  endtask

  // One clock of stimulus. The expected entry is queued when the model says
  // the word is accepted; occupancy and handshake flags are checked after the edge.
  task automatic cycle(input logic fv, input int vi, input logic [31:0] addr,
                       input logic ir, input logic fl);
    logic acc;
    logic deq;
    fetch_valid       = fv;
    fetch_instruction = vtab[vi].ins;
    fetch_address     = addr;
    issue_ready       = ir;
    flush             = fl;
    acc = fv && (model_occ != 4) && !fl;
    deq = ir && (model_occ != 0) && !fl;
    if (acc) exp_q.push_back('{vtab[vi].ins, addr, vtab[vi].dec, vtab[vi].imm, vtab[vi].ill});
    @(posedge clock);
    #1;
    if (fl) begin
      exp_q.delete();
      model_occ = 0;
    end else begin
      model_occ = model_occ + int'(acc) - int'(deq);
    end
    chk("occupancy", {29'b0, occupancy}, 32'(model_occ));
    chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, model_occ != 4});
    chk("issue_valid", {31'b0, issue_valid}, {31'b0, model_occ != 0});
  endtask

  task automatic idle();
    cycle(1'b0, 0, 32'h0, 1'b0, 1'b0);
  endtask

  // Monitor: every issue handshake must match the oldest queued expectation
  always @(negedge clock) begin
    if (reset_n && issue_valid && issue_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL issue: unexpected word %08h at %08h, none expected",
                 issue_instruction, issue_address);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (issue_instruction !== e.ins || issue_address !== e.addr ||
            issue_decoded !== e.dec || issue_immediate !== e.imm ||
            issue_illegal !== e.ill) begin
          miscompares++;
          $display("FAIL issue: got ins=%08h addr=%08h dec=%03h imm=%08h ill=%0b expected ins=%08h addr=%08h dec=%03h imm=%08h ill=%0b",
                   issue_instruction, issue_address, issue_decoded, issue_immediate, issue_illegal,
                   e.ins, e.addr, e.dec, e.imm, e.ill);
        end else begin
          $display("ok   issue: ins=%08h addr=%08h dec=%03h imm=%08h ill=%0b",
                   issue_instruction, issue_address, issue_decoded, issue_immediate, issue_illegal);
        end
      end
    end
  end

  initial begin
    reset_n           = 1'b0;
    fetch_valid       = 1'b0;
    fetch_instruction = 32'h0;
    fetch_address     = 32'h0;
    flush             = 1'b0;
    issue_ready       = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_empty("reset");
    reset_n = 1'b1;
    idle();

    // Single addi at 0x100, held at head, then issued
    cycle(1'b1, 0, 32'h100, 1'b0, 1'b0);
    chk("head issue_address",   issue_address, 32'h100);
    chk("head issue_immediate", issue_immediate, 32'h5);
    chk("head issue_decoded",   {22'b0, issue_decoded}, 32'h012);
    cycle(1'b0, 0, 32'h0, 1'b1, 1'b0);
    check_empty("after drain");

    // Fill with branch/store/lui/illegal, fifth word refused while full
    for (int i = 1; i <= 4; i++) cycle(1'b1, i, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
    cycle(1'b1, 5, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, 5, 32'h300, 1'b1, 1'b0);   // one issue, fetch still blocked this cycle
    cycle(1'b1, 5, 32'h300, 1'b0, 1'b0);   // now accepted
    repeat (4) cycle(1'b0, 0, 32'h0, 1'b1, 1'b0);

    // Simultaneous enqueue/dequeue at occupancy 2, pointers wrap repeatedly
    cycle(1'b1, 6, 32'h400, 1'b0, 1'b0);
    cycle(1'b1, 7, 32'h404, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8 + (i % 6), 32'h408 + 32'(4 * i), 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 0, 32'h0, 1'b1, 1'b0);

    // Flush at occupancy 3 with a concurrent jal fetch
    for (int i = 0; i < 3; i++) cycle(1'b1, 9 + i, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
    cycle(1'b1, 5, 32'h600, 1'b0, 1'b1);
    check_empty("after flush");
    cycle(1'b1, 13, 32'h700, 1'b0, 1'b0);
    cycle(1'b0, 0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream
    cycle(1'b1, 1, 32'h800, 1'b0, 1'b0);
    cycle(1'b1, 2, 32'h804, 1'b0, 1'b0);
    fetch_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_empty("async reset");
    exp_q.delete();
    model_occ = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle();
    check_empty("post reset");
    cycle(1'b1, 3, 32'h900, 1'b0, 1'b0);
    cycle(1'b0, 0, 32'h0, 1'b1, 1'b0);
    idle();

    chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
